// File: rtl/clk_div_ctrl_if.sv
// rtl/clk_div_ctrl_if.sv - configuration handshake and clock outputs of clk_div_ctrl
interface clk_div_ctrl_if #(parameter int DW = 8);
  logic          CFG_VALID;
  logic          CFG_READY;
  logic [1:0]    CFG_SEL;
  logic [DW-1:0] CFG_DIV;
  logic          CFG_EN;
  logic          CFG_ERR;
  logic [2:0]    CLK_OUT;
  logic [2:0]    TC;
  logic          BUSY;

  modport master (
    output CFG_VALID, CFG_SEL, CFG_DIV, CFG_EN,
    input  CFG_READY, CFG_ERR, CLK_OUT, TC, BUSY
  );

  modport slave (
    input  CFG_VALID, CFG_SEL, CFG_DIV, CFG_EN,
    output CFG_READY, CFG_ERR, CLK_OUT, TC, BUSY
  );
endinterface

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - three-channel clock divider with glitch-free runtime reconfiguration
module clk_div_ctrl #(
  parameter int DW = 8
) (
  input  logic          CLK_in,
  input  logic          RST,
  clk_div_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT_TC, APPLY} state_t;

  localparam logic [DW-1:0] ONE      = DW'(1);
  localparam logic [DW-1:0] DIV0_RST = DW'(1);
  localparam logic [DW-1:0] DIV1_RST = DW'(5);
  localparam logic [DW-1:0] DIV2_RST = DW'(50);

  // channel state
  logic [DW-1:0] r_cnt [3];
  logic [DW-1:0] r_div [3];
  logic [2:0]    r_en;
  logic [2:0]    r_clk;
  logic [2:0]    r_tc;

  // controller state and captured request
  state_t        r_state;
  logic [1:0]    r_sel;
  logic [DW-1:0] r_cap_div;
  logic          r_cap_en;
  logic          r_err;
  logic          r_ready;
  logic          r_busy;

  logic [2:0]    w_term;
  logic [2:0]    w_sel_oh;
  logic [2:0]    w_req_oh;
  logic          w_hs;
  logic          w_illegal;
  logic          w_tgt_term;
  logic          w_load_wait;
  logic          w_load_apply;

  // terminal count: an enabled channel whose counter reached div-1 this cycle
  always_comb begin
    w_term = '0;
    for (int i = 0; i < 3; i++) begin
      w_term[i] = r_en[i] && (r_cnt[i] == (r_div[i] - ONE));
    end
  end

  assign w_sel_oh     = 3'b001 << r_sel;
  assign w_req_oh     = 3'b001 << bus.CFG_SEL;
  assign w_hs         = bus.CFG_VALID && r_ready;
  assign w_illegal    = (bus.CFG_SEL == 2'd3) || (bus.CFG_DIV == '0);
  assign w_tgt_term   = |(w_term & w_sel_oh);
  // a running channel only takes new settings on its own toggle edge, so no phase is cut short
  assign w_load_wait  = (r_state == WAIT_TC) && w_tgt_term;
  assign w_load_apply = (r_state == APPLY);

  // per-channel counters, divided clocks and terminal-count pulses
  always_ff @(posedge CLK_in or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 3; i++) begin
        r_cnt[i] <= '0;
      end
      r_div[0] <= DIV0_RST;
      r_div[1] <= DIV1_RST;
      r_div[2] <= DIV2_RST;
      r_en     <= 3'b111;
      r_clk    <= 3'b000;
      r_tc     <= 3'b000;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (w_sel_oh[i] && (w_load_wait || w_load_apply)) begin
          r_div[i] <= r_cap_div;
          r_en[i]  <= r_cap_en;
          r_cnt[i] <= '0;
          // the boundary toggle still happens on a WAIT_TC load; APPLY targets an idle channel
          r_clk[i] <= w_load_wait ? ~r_clk[i] : r_clk[i];
          r_tc[i]  <= w_load_wait;
        end else if (w_term[i]) begin
          r_cnt[i] <= '0;
          r_clk[i] <= ~r_clk[i];
          r_tc[i]  <= 1'b1;
        end else if (r_en[i]) begin
          r_cnt[i] <= r_cnt[i] + ONE;
          r_tc[i]  <= 1'b0;
        end else begin
          r_cnt[i] <= '0;
          r_tc[i]  <= 1'b0;
        end
      end
    end
  end

  // request controller: validate, capture, then wait for a safe boundary or apply at once
  always_ff @(posedge CLK_in or posedge RST) begin
    if (RST) begin
      r_state   <= IDLE;
      r_sel     <= 2'd0;
      r_cap_div <= '0;
      r_cap_en  <= 1'b0;
      r_err     <= 1'b0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_hs) begin
            if (w_illegal) begin
              r_err <= 1'b1;
            end else begin
              r_sel     <= bus.CFG_SEL;
              r_cap_div <= bus.CFG_DIV;
              r_cap_en  <= bus.CFG_EN;
              r_ready   <= 1'b0;
              r_busy    <= 1'b1;
              if (|(r_en & w_req_oh)) begin
                r_state <= WAIT_TC;
              end else begin
                r_state <= APPLY;
              end
            end
          end
        end
        WAIT_TC: begin
          if (w_tgt_term) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        APPLY: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.CFG_READY = r_ready;
  assign bus.CFG_ERR   = r_err;
  assign bus.BUSY      = r_busy;
  assign bus.CLK_OUT   = r_clk;
  assign bus.TC        = r_tc;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb/tb_clk_div_ctrl.sv - self-checking bench for clk_div_ctrl
module tb_clk_div_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  clk_div_ctrl_if #(.DW(8)) bus ();

  clk_div_ctrl #(.DW(8)) dut (
    .CLK_in (clk),
    .RST    (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // model: each channel is described by the absolute edge number of its next toggle
  int         m_t;
  int         m_next [3];
  int         m_div  [3];
  bit         m_en   [3];
  logic [2:0] m_clk;
  logic [2:0] m_tc;
  bit         m_pend;
  bit         m_apply;
  int         m_psel;
  int         m_pdiv;
  bit         m_pen;
  bit         m_err;

  // advance the model by one input-clock edge
  always @(posedge clk or posedge rst) begin
    bit tog [3];
    bit pend0;
    int ld;
    if (rst) begin
      m_t = 0;
      m_div[0] = 1; m_div[1] = 5; m_div[2] = 50;
      for (int i = 0; i < 3; i++) begin
        m_en[i] = 1'b1;
        m_next[i] = m_div[i];
      end
      m_clk = 3'b000; m_tc = 3'b000;
      m_pend = 1'b0; m_apply = 1'b0; m_err = 1'b0;
      m_psel = 0; m_pdiv = 1; m_pen = 1'b0;
    end else begin
      m_t++;
      pend0 = m_pend;
      ld = -1;
      for (int i = 0; i < 3; i++) tog[i] = m_en[i] && (m_t == m_next[i]);
      if (m_pend && (m_apply || tog[m_psel])) begin
        ld = m_psel;
        m_pend = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
        m_tc[i] = tog[i];
        if (tog[i]) begin
          m_clk[i] = ~m_clk[i];
          m_next[i] = m_next[i] + m_div[i];
        end
      end
      if (ld >= 0) begin
        m_div[ld] = m_pdiv;
        m_en[ld] = m_pen;
        m_next[ld] = m_t + m_pdiv;
      end
      m_err = 1'b0;
      if (!pend0 && bus.CFG_VALID) begin
        if (bus.CFG_SEL == 2'd3 || bus.CFG_DIV == 8'd0) begin
          m_err = 1'b1;
        end else begin
          m_pend = 1'b1;
          m_psel = int'(bus.CFG_SEL);
          m_pdiv = int'(bus.CFG_DIV);
          m_pen = bus.CFG_EN;
          m_apply = !m_en[m_psel];
        end
      end
    end
  end

  // every cycle: DUT outputs against the model
  always @(negedge clk) begin
    check("clk_out", bus.CLK_OUT, m_clk);
    check("tc", bus.TC, m_tc);
    check("busy", bus.BUSY, m_pend);
    check("cfg_ready", bus.CFG_READY, !m_pend);
    check("cfg_err", bus.CFG_ERR, m_err);
  end

  task automatic send(input logic [1:0] s, input logic [7:0] d, input logic e);
    bus.CFG_VALID = 1'b1; bus.CFG_SEL = s; bus.CFG_DIV = d; bus.CFG_EN = e;
    @(negedge clk);
    bus.CFG_VALID = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (bus.BUSY && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // lengths of the next n complete phases of one channel
  task automatic phases(input int ch, input int n, output int mn, output int mx);
    int len, seen, guard;
    logic p;
    mn = 1000; mx = 0; len = 0; seen = -1; guard = 0; p = bus.CLK_OUT[ch];
    while (seen < n && guard < 1000) begin
      @(negedge clk);
      guard++; len++;
      if (bus.CLK_OUT[ch] !== p) begin
        if (seen >= 0) begin
          if (len < mn) mn = len;
          if (len > mx) mx = len;
        end
        seen++; len = 0; p = bus.CLK_OUT[ch];
      end
    end
    check("phase_wait", seen, n);
  endtask

  // edge number of each channel's first toggle and toggle/TC counts over n edges
  task automatic run_edges(input int n, output int first [3], output int togc [3], output int tcc [3]);
    logic [2:0] prev;
    prev = bus.CLK_OUT;
    for (int i = 0; i < 3; i++) begin first[i] = 0; togc[i] = 0; tcc[i] = 0; end
    for (int e = 1; e <= n; e++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (bus.CLK_OUT[i] !== prev[i]) begin
          togc[i]++;
          if (first[i] == 0) first[i] = e;
        end
        if (bus.TC[i] === 1'b1) tcc[i]++;
      end
      prev = bus.CLK_OUT;
    end
  endtask

  initial begin
    int first [3];
    int togc [3];
    int tcc [3];
    int cyc, mn, mx, g, errs, chg;
    logic frz;

    rst = 1'b1;
    bus.CFG_VALID = 1'b0; bus.CFG_SEL = 2'd0; bus.CFG_DIV = 8'd1; bus.CFG_EN = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_clk_out", bus.CLK_OUT, 3'b000);
    check("rst_tc", bus.TC, 3'b000);
    check("rst_busy", bus.BUSY, 1'b0);
    check("rst_ready", bus.CFG_READY, 1'b1);
    check("rst_err", bus.CFG_ERR, 1'b0);
    rst = 1'b0;

    // free run from reset
    run_edges(200, first, togc, tcc);
    check("first_tog0", first[0], 1);
    check("first_tog1", first[1], 5);
    check("first_tog2", first[2], 50);
    check("toggles0", togc[0], 200);
    check("toggles1", togc[1], 40);
    check("toggles2", togc[2], 4);
    check("tc_count0", tcc[0], 200);
    check("tc_count1", tcc[1], 40);
    check("tc_count2", tcc[2], 4);

    // reconfigure a running channel mid-phase
    @(negedge clk);
    send(2'd1, 8'd3, 1'b1);
    check("wait_busy", bus.BUSY, 1'b1);
    wait_idle(cyc);
    check("wait_busy_cycles", cyc, 3);
    check("load_edge_tc1", bus.TC[1], 1'b1);
    phases(1, 4, mn, mx);
    check("ch1_new_min_phase", mn, 3);
    check("ch1_new_max_phase", mx, 3);

    // illegal requests
    send(2'd3, 8'd5, 1'b1);
    check("sel3_err", bus.CFG_ERR, 1'b1);
    check("sel3_ready", bus.CFG_READY, 1'b1);
    @(negedge clk);
    check("sel3_err_clear", bus.CFG_ERR, 1'b0);
    send(2'd0, 8'd0, 1'b1);
    check("div0_err", bus.CFG_ERR, 1'b1);
    check("div0_busy", bus.BUSY, 1'b0);
    @(negedge clk);
    check("div0_err_clear", bus.CFG_ERR, 1'b0);
    phases(1, 2, mn, mx);
    check("ch1_kept_phase", mx, 3);
    phases(0, 2, mn, mx);
    check("ch0_kept_phase", mx, 1);

    // disable channel 2, then re-enable through APPLY
    send(2'd2, 8'd50, 1'b0);
    wait_idle(cyc);
    check("disable_done", bus.BUSY, 1'b0);
    frz = bus.CLK_OUT[2];
    chg = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.CLK_OUT[2] !== frz || bus.TC[2] !== 1'b0) chg++;
    end
    check("ch2_frozen", chg, 0);
    send(2'd2, 8'd2, 1'b1);
    wait_idle(cyc);
    check("apply_busy_cycles", cyc, 1);
    phases(2, 3, mn, mx);
    check("ch2_min_phase", mn, 2);
    check("ch2_max_phase", mx, 2);

    // request held while busy is taken in the first idle cycle
    send(2'd1, 8'd4, 1'b1);
    bus.CFG_VALID = 1'b1; bus.CFG_SEL = 2'd0; bus.CFG_DIV = 8'd2; bus.CFG_EN = 1'b1;
    g = 0; errs = 0;
    while (!bus.CFG_READY && g < 100) begin
      @(negedge clk);
      g++;
      if (bus.CFG_ERR) errs++;
    end
    @(negedge clk);
    bus.CFG_VALID = 1'b0;
    check("held_no_err", errs, 0);
    check("held_accepted", bus.BUSY, 1'b1);
    wait_idle(cyc);
    phases(0, 3, mn, mx);
    check("ch0_new_phase", mx, 2);

    // reset while an update is pending
    send(2'd1, 8'd7, 1'b1);
    check("busy_before_rst", bus.BUSY, 1'b1);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst2_clk_out", bus.CLK_OUT, 3'b000);
    check("rst2_busy", bus.BUSY, 1'b0);
    check("rst2_ready", bus.CFG_READY, 1'b1);
    rst = 1'b0;
    run_edges(60, first, togc, tcc);
    check("rst2_first_tog0", first[0], 1);
    check("rst2_first_tog1", first[1], 5);
    check("rst2_first_tog2", first[2], 50);
    check("rst2_toggles1", togc[1], 12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 The block SHALL have parameter DW, default 8, setting the width of the half-period divide count.
REQ-002 Port CLK_in, input, 1 bit: the single clock; all state SHALL change on its rising edge only.
REQ-003 Port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-004 Port CFG_VALID, input, 1 bit: a configuration request is present.
REQ-005 Port CFG_READY, output, 1 bit: the block can accept a request this cycle.
REQ-006 Port CFG_SEL, input, 2 bits: target channel; 0..2 are valid and 3 is illegal.
REQ-007 Port CFG_DIV, input, DW bits: new half-period count, in input-clock cycles; 0 is illegal.
REQ-008 Port CFG_EN, input, 1 bit: new enable for the target channel.
REQ-009 Port CFG_ERR, output, 1 bit: one-cycle pulse flagging a rejected request.
REQ-010 Port CLK_OUT, output, 3 bits: divided clocks, one per channel.
REQ-011 Port TC, output, 3 bits: one-cycle terminal-count pulse per channel.
REQ-012 Port BUSY, output, 1 bit: an accepted update is still pending.

Function
REQ-013 Each channel SHALL keep three registers: a DW-bit counter cnt, a DW-bit divide register div, and an enable bit en.
REQ-014 When a channel is enabled and cnt is not div-1, cnt SHALL increment by 1 each cycle.
REQ-015 When a channel is enabled and cnt equals div-1:
- cnt SHALL clear to 0;
- CLK_OUT for that channel SHALL toggle;
- TC for that channel SHALL pulse high on the same edge.
REQ-016 The output period SHALL be 2*div input cycles; div=1 gives divide-by-2.
REQ-017 A disabled channel SHALL hold CLK_OUT, hold cnt at 0, and keep TC at 0.
REQ-018 The request handshake SHALL complete when CFG_VALID and CFG_READY are both high on a rising edge; CFG_SEL, CFG_DIV and CFG_EN SHALL be captured on that edge.
REQ-019 The controller FSM SHALL have three states: IDLE, WAIT_TC and APPLY.
REQ-020 CFG_READY SHALL be high only in IDLE, and BUSY SHALL equal (state != IDLE).
REQ-021 A request with CFG_SEL=3 or CFG_DIV=0 SHALL be rejected:
- CFG_ERR pulses for one cycle after the handshake;
- no register changes;
- the FSM stays in IDLE.
REQ-022 An accepted legal request to a currently disabled channel SHALL go IDLE->APPLY.
REQ-023 An accepted legal request to a currently enabled channel SHALL go IDLE->WAIT_TC.
REQ-024 In WAIT_TC, on the edge where the target channel's terminal count occurs:
- div and en SHALL load from the captured values;
- cnt SHALL clear;
- the CLK_OUT toggle of REQ-015 SHALL still occur;
- the FSM SHALL move to IDLE.
REQ-025 An update made through WAIT_TC SHALL never produce a CLK_OUT high or low phase shorter than min(old div, new div).
REQ-026 In APPLY, div and en SHALL load, cnt SHALL clear, CLK_OUT SHALL hold its value, and the FSM SHALL return to IDLE after one cycle.
REQ-027 While BUSY is high, CFG_VALID SHALL be ignored and no error SHALL be flagged.
REQ-028 Channels not targeted by a pending update SHALL keep running unaffected.
REQ-029 If a captured CFG_EN is 0, the channel SHALL stop at the boundary where the update applies, holding the CLK_OUT value present after that edge.
REQ-030 The FSM SHALL accept a new request on the first cycle after returning to IDLE, giving a best-case throughput of one update per 2 cycles.

Reset
REQ-031 While RST is high, the block SHALL hold these values:
- CLK_OUT=000, TC=000, cnt=0 on all channels;
- div0=1, div1=5, div2=50, en=111;
- FSM in IDLE, CFG_ERR=0, BUSY=0;
- CFG_READY=1.
REQ-032 An RST assertion during WAIT_TC or APPLY SHALL discard the pending update.
REQ-033 After RST deasserts, channel 0 SHALL first toggle on the 1st rising edge, channel 1 on the 5th, and channel 2 on the 50th.

Verification
REQ-034 Release reset and run 200 cycles -> CLK_OUT[0] period 2, CLK_OUT[1] period 10, CLK_OUT[2] period 100, with one TC pulse per toggle.
REQ-035 Request SEL=1, DIV=3, EN=1 while cnt1=1 -> BUSY stays high until cnt1=4; the new period is 6, and no phase is shorter than 3 cycles.
REQ-036 Request SEL=3, or request DIV=0 -> CFG_ERR pulses once, every div/en register is unchanged, and CFG_READY stays 1.
REQ-037 Disable channel 2 (EN=0), then re-enable it with DIV=2 -> CLK_OUT[2] freezes; after re-enable it takes the APPLY path and toggles every 2 cycles.
REQ-038 Hold CFG_VALID high with a new request while BUSY is high -> no handshake and no error; the request is accepted in the first IDLE cycle.
REQ-039 Assert RST mid-WAIT_TC -> the pending update is lost and all registers return to the REQ-031 values.
